svo_timing_gen: RTL and testbench

Video timing generator and pixel pacer that sits directly upstream of the per-channel TMDS encoders.
- Runs the horizontal and vertical raster counters and pulls RGB pixels from a valid/ready stream during active video.
- Produces registered de, hsync, vsync and 8-bit R/G/B in the pixel clock domain.
- The blue encoder's ctrl input is driven with {vsync, hsync}; the red and green encoders' ctrl inputs are tied to 2'b00.

---
 rtl/svo_pkg.sv | 49 ++++
 rtl/svo_pattern_gen.sv | 22 ++
 rtl/svo_timing_gen.sv | 155 +++++++++++++++
 tb/tb_svo_timing_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/svo_pkg.sv
// svo_pkg: shared constants and types for the svo video timing slice.
// Holds default 640x480 timing, the RGB888 pixel type, TMDS control-word
// constants and the colour-bar lookup used by the optional test pattern.
package svo_pkg;

   // Default 640x480 @ 60 Hz raster timing (pixel clocks / lines).
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam bit DEF_HS_POL   = 1'b0;
   localparam bit DEF_VS_POL   = 1'b0;

   // Raster counters are 12 bits wide, so totals must not exceed 4096.
   localparam int CNT_W = 12;

   // TMDS control inputs: blue carries {vsync, hsync}, red and green idle.
   localparam logic [1:0] TMDS_CTRL_IDLE = 2'b00;
   localparam int         TMDS_CTRL_HS  = 0;
   localparam int         TMDS_CTRL_VS  = 1;

   // One pixel, laid out so that a 24-bit {R, G, B} word casts directly.
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   // Eight classic colour bars, full-scale 255/0 levels, left to right.
   function automatic rgb888_t barColour(input logic [31:0] idx);
      rgb888_t c;
      case (idx)
         32'd0:   c = '{8'hFF, 8'hFF, 8'hFF};
         32'd1:   c = '{8'hFF, 8'hFF, 8'h00};
         32'd2:   c = '{8'h00, 8'hFF, 8'hFF};
         32'd3:   c = '{8'h00, 8'hFF, 8'h00};
         32'd4:   c = '{8'hFF, 8'h00, 8'hFF};
         32'd5:   c = '{8'hFF, 8'h00, 8'h00};
         32'd6:   c = '{8'h00, 8'h00, 8'hFF};
         default: c = '{8'h00, 8'h00, 8'h00};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/svo_pattern_gen.sv
// svo_pattern_gen: combinational 8-bar colour pattern indexed by h_cnt.
// Only built when SVO_TESTPATTERN_EN is defined; otherwise this file is empty.
`ifdef SVO_TESTPATTERN_EN
module svo_pattern_gen
   import svo_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE
) (
   input  logic [CNT_W-1:0] i_hCnt,
   output rgb888_t          o_rgb
);

   logic [31:0] w_barIdx;

   // Scale the horizontal position so the active width spans eight equal bars.
   always_comb begin
      w_barIdx = ({20'd0, i_hCnt} << 3) / 32'(H_ACTIVE);
      o_rgb    = barColour(w_barIdx);
   end

endmodule
`endif

// File: rtl/svo_timing_gen.sv
// svo_timing_gen: raster counters, region decode and registered video outputs
// feeding the TMDS encoders. Pixels are pulled from a valid/ready stream during
// active video; a missing pixel is replaced by black and flagged as underflow.
// Optional macro SVO_TESTPATTERN_EN adds pattern_sel and internal colour bars.
module svo_timing_gen
   import svo_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = DEF_HS_POL,
   parameter bit VS_POL   = DEF_VS_POL
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_data,
   input  logic        clear_flags,
   output logic        de,
   output logic        hsync,
   output logic        vsync,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        frame_start,
   output logic        underflow
`ifdef SVO_TESTPATTERN_EN
   ,
   input  logic        pattern_sel
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   logic [CNT_W-1:0] r_hCnt;
   logic [CNT_W-1:0] r_vCnt;
   logic             r_de;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_frameStart;
   logic             r_underflow;
   rgb888_t          r_pix;

   logic    w_active;
   logic    w_hSyncRgn;
   logic    w_vSyncRgn;
   logic    w_inReady;
   logic    w_underflowSet;
   logic    w_patSel;
   rgb888_t w_barPix;
   rgb888_t w_pixNext;

`ifdef SVO_TESTPATTERN_EN
   assign w_patSel = pattern_sel;

   svo_pattern_gen #(
      .H_ACTIVE (H_ACTIVE)
   ) u_patternGen (
      .i_hCnt (r_hCnt),
      .o_rgb  (w_barPix)
   );
`else
   assign w_patSel = 1'b0;
   assign w_barPix = '0;
`endif

   // Region decode from the registered counters only, so in_ready never
   // depends on in_valid; reset forces in_ready low even while enabled.
   always_comb begin
      w_active       = (int'(r_hCnt) < H_ACTIVE) && (int'(r_vCnt) < V_ACTIVE);
      w_hSyncRgn     = (int'(r_hCnt) >= H_SYNC_START) && (int'(r_hCnt) < H_SYNC_START + H_SYNC);
      w_vSyncRgn     = (int'(r_vCnt) >= V_SYNC_START) && (int'(r_vCnt) < V_SYNC_START + V_SYNC);
      w_inReady      = resetn && enable && w_active && !w_patSel;
      w_underflowSet = w_inReady && !in_valid;
   end

   // Choose the pixel for the next output cycle: bars, accepted data or black.
   always_comb begin
      w_pixNext = '0;
      if (w_patSel) begin
         if (enable && w_active) begin
            w_pixNext = w_barPix;
         end
      end else if (w_inReady && in_valid) begin
         w_pixNext = rgb888_t'(in_data);
      end
   end

   // Free-running raster counters; disabling snaps them back to the origin.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_hCnt <= '0;
         r_vCnt <= '0;
      end else if (!enable) begin
         r_hCnt <= '0;
         r_vCnt <= '0;
      end else if (r_hCnt == H_LAST) begin
         r_hCnt <= '0;
         r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + 1'b1;
      end else begin
         r_hCnt <= r_hCnt + 1'b1;
      end
   end

   // Output register: every video output lags the counter state by one clock.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_de         <= 1'b0;
         r_hsync      <= ~HS_POL;
         r_vsync      <= ~VS_POL;
         r_frameStart <= 1'b0;
         r_pix        <= '0;
      end else begin
         r_de         <= enable && w_active;
         r_hsync      <= (enable && w_hSyncRgn) ? HS_POL : ~HS_POL;
         r_vsync      <= (enable && w_vSyncRgn) ? VS_POL : ~VS_POL;
         r_frameStart <= enable && (r_hCnt == '0) && (r_vCnt == '0);
         r_pix        <= w_pixNext;
      end
   end

   // Sticky underflow; a new underflow outranks a simultaneous clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_underflow <= 1'b0;
      end else if (w_underflowSet) begin
         r_underflow <= 1'b1;
      end else if (clear_flags) begin
         r_underflow <= 1'b0;
      end
   end

   assign in_ready    = w_inReady;
   assign de          = r_de;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign r           = r_pix.r;
   assign g           = r_pix.g;
   assign b           = r_pix.b;
   assign frame_start = r_frameStart;
   assign underflow   = r_underflow;

endmodule

// File: tb/tb_svo_timing_gen.sv
// tb_svo_timing_gen: scoreboard bench for svo_timing_gen on a tiny 8x5 raster.
// Stimulus pushes expected pixels into a queue; a negedge monitor pops them
// whenever de is high. Timing outputs are checked against a small raster model.
module tb_svo_timing_gen;

   localparam int HA = 4;
   localparam int HF = 1;
   localparam int HS = 2;
   localparam int HB = 1;
   localparam int VA = 2;
   localparam int VF = 1;
   localparam int VS = 1;
   localparam int VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   typedef struct {
      logic [23:0] rgb;
      logic        fs;
   } exp_t;

   logic        clk;
   logic        resetn;
   logic        enable;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_data;
   logic        clear_flags;
   logic        de;
   logic        hsync;
   logic        vsync;
   logic [7:0]  r;
   logic [7:0]  g;
   logic [7:0]  b;
   logic        frame_start;
   logic        underflow;
`ifdef SVO_TESTPATTERN_EN
   logic        pattern_sel;
`endif

   exp_t        sbQ[$];
   int          checks   = 0;
   int          failures = 0;
   int          mH;
   int          mV;
   logic        mEn;
   logic        patSel;
   logic        expUnder;
   logic [23:0] pixData;

   svo_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .HS_POL   (1'b0), .VS_POL (1'b0)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .enable      (enable),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .clear_flags (clear_flags),
      .de          (de),
      .hsync       (hsync),
      .vsync       (vsync),
      .r           (r),
      .g           (g),
      .b           (b),
      .frame_start (frame_start),
`ifdef SVO_TESTPATTERN_EN
      .underflow   (underflow),
      .pattern_sel (pattern_sel)
`else
      .underflow   (underflow)
`endif
   );

   // Pixel clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected colour bar for a column of the 4-pixel-wide test raster.
   function automatic logic [23:0] barExp(input int h);
      int idx;
      idx = (h * 8) / HA;
      case (idx)
         0:       return 24'hFFFFFF;
         1:       return 24'hFFFF00;
         2:       return 24'h00FFFF;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'hFF0000;
         6:       return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // One comparison: count it, and report actual versus required on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one clock of inputs, record expectations from the raster model,
   // cross the edge and check the registered timing outputs.
   task automatic applyStimulus(input logic valid, input logic [23:0] data, input logic clr);
      logic active;
      logic expReady;
      logic expDe;
      logic expHs;
      logic expVs;
      exp_t e;
      in_valid    = valid;
      in_data     = data;
      clear_flags = clr;
      active   = (mH < HA) && (mV < VA);
      expReady = mEn && active && !patSel;
      expDe    = mEn && active;
      expHs    = !(mEn && mH >= HA + HF && mH < HA + HF + HS);
      expVs    = !(mEn && mV >= VA + VF && mV < VA + VF + VS);
      #1;
      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      if (expDe) begin
         e.rgb = patSel ? barExp(mH) : (valid ? data : 24'h0);
         e.fs  = (mH == 0) && (mV == 0);
         sbQ.push_back(e);
      end
      if (expReady && !valid) expUnder = 1'b1;
      else if (clr)           expUnder = 1'b0;
      @(posedge clk);
      if (!mEn) begin
         mH = 0;
         mV = 0;
      end else if (mH == HT - 1) begin
         mH = 0;
         mV = (mV == VT - 1) ? 0 : mV + 1;
      end else begin
         mH++;
      end
      #1;
      checkOutput("de", 32'(de), 32'(expDe));
      checkOutput("hsync", 32'(hsync), 32'(expHs));
      checkOutput("vsync", 32'(vsync), 32'(expVs));
      checkOutput("underflow", 32'(underflow), 32'(expUnder));
   endtask

   // One cycle fed from the incrementing pixel source.
   task automatic stepCycle(input logic valid, input logic clr);
      logic acc;
      acc = mEn && (mH < HA) && (mV < VA) && !patSel && valid;
      applyStimulus(valid, pixData, clr);
      if (acc) pixData++;
   endtask

   // Scoreboard monitor: pop and compare whenever the DUT presents a pixel.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (de === 1'b1) begin
            checkOutput("sb_pending", 32'(sbQ.size() > 0), 32'd1);
            if (sbQ.size() > 0) begin
               e = sbQ.pop_front();
               checkOutput("pixel_rgb", {8'h0, r, g, b}, {8'h0, e.rgb});
               checkOutput("frame_start", 32'(frame_start), 32'(e.fs));
            end
         end else begin
            checkOutput("frame_start_idle", 32'(frame_start), 32'd0);
            checkOutput("rgb_idle", {8'h0, r, g, b}, 32'd0);
         end
      end
   end

   initial begin
      resetn      = 1'b1;
      enable      = 1'b0;
      in_valid    = 1'b0;
      in_data     = 24'h0;
      clear_flags = 1'b0;
      patSel      = 1'b0;
`ifdef SVO_TESTPATTERN_EN
      pattern_sel = 1'b0;
`endif
      mH = 0; mV = 0; mEn = 1'b0; expUnder = 1'b0; pixData = 24'h000001;

      // Asynchronous reset before any clock edge.
      #2 resetn = 1'b0;
      #1;
      checkOutput("rst_de", 32'(de), 32'd0);
      checkOutput("rst_hsync", 32'(hsync), 32'd1);
      checkOutput("rst_vsync", 32'(vsync), 32'd1);
      checkOutput("rst_rgb", {8'h0, r, g, b}, 32'd0);
      checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
      checkOutput("rst_underflow", 32'(underflow), 32'd0);
      enable = 1'b1;
      #1 checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      enable = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b1;

      // Idle while disabled, then two full frames of continuous pixels.
      for (int i = 0; i < 3; i++) stepCycle(1'b1, 1'b0);
      enable = 1'b1; mEn = 1'b1;
      for (int i = 0; i < 2 * HT * VT; i++) stepCycle(1'b1, 1'b0);

      // Starve pixel (2,1) for one frame; underflow must stick.
      for (int i = 0; i < HT * VT; i++) stepCycle(!(mH == 2 && mV == 1), 1'b0);
      stepCycle(1'b1, 1'b1);
      for (int i = 0; i < HT * VT && !((mH < HA) && (mV < VA)); i++) stepCycle(1'b1, 1'b0);
      stepCycle(1'b0, 1'b1);
      stepCycle(1'b1, 1'b0);
      stepCycle(1'b1, 1'b1);

      // Drop enable at h=2, v=1, then re-enable and run a frame.
      for (int i = 0; i < HT * VT && !(mH == 2 && mV == 1); i++) stepCycle(1'b1, 1'b0);
      enable = 1'b0; mEn = 1'b0;
      for (int i = 0; i < 3; i++) stepCycle(1'b1, 1'b0);
      enable = 1'b1; mEn = 1'b1;
      for (int i = 0; i < HT * VT + 5; i++) stepCycle(1'b1, 1'b0);

      // Leave underflow set, then reset asynchronously while a pixel is out.
      for (int i = 0; i < HT * VT && !(mH == 0 && mV == 1); i++) stepCycle(1'b1, 1'b0);
      stepCycle(1'b0, 1'b0);
      #2 resetn = 1'b0;
      #1;
      checkOutput("async_de", 32'(de), 32'd0);
      checkOutput("async_rgb", {8'h0, r, g, b}, 32'd0);
      checkOutput("async_frame_start", 32'(frame_start), 32'd0);
      checkOutput("async_underflow", 32'(underflow), 32'd0);
      checkOutput("async_hsync", 32'(hsync), 32'd1);
      checkOutput("async_vsync", 32'(vsync), 32'd1);
      sbQ.delete();
      @(posedge clk);
      #1 resetn = 1'b1;
      mH = 0; mV = 0; expUnder = 1'b0;
      for (int i = 0; i < HT * VT + 3; i++) stepCycle(1'b1, 1'b0);

`ifdef SVO_TESTPATTERN_EN
      // Colour bars: no requests and no underflow even with in_valid low.
      patSel = 1'b1; pattern_sel = 1'b1;
      for (int i = 0; i < HT * VT; i++) stepCycle(1'b0, 1'b0);
      patSel = 1'b0; pattern_sel = 1'b0;
`endif

      for (int i = 0; i < HT; i++) stepCycle(1'b1, 1'b0);
      @(negedge clk);
      #1 checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
